// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts a
// byte plus odd parity on device clocks, presents the stop bit and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_STOP,
    S_ACK,
    S_WAITIDLE
  } state_t;

  logic                  clk_sync_p0, clk_sync_p1;
  logic                  data_sync_p0, data_sync_p1;
  logic [FILTER_LEN-1:0] clk_hist_p2;
  logic                  clk_filt_p3;
  logic                  fall_p3;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [3:0]            bitcnt, bitcnt_nxt;
  logic [8:0]            shreg, shreg_nxt;
  logic                  done_nxt, err_nxt;
  logic                  timeout;

  // Stage p0/p1: two-flop synchronizers for the asynchronous pad inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk_i;
      clk_sync_p1  <= clk_sync_p0;
      data_sync_p0 <= ps2_data_i;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // Stage p2/p3: the filtered clock only moves once the whole history agrees;
  // fall is registered alongside so it coincides with the filtered 1->0 change
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_hist_p2 <= '1;
      clk_filt_p3 <= 1'b1;
      fall_p3     <= 1'b0;
    end else begin
      clk_hist_p2 <= {clk_hist_p2[FILTER_LEN-2:0], clk_sync_p1};
      fall_p3     <= clk_filt_p3 & ~(|clk_hist_p2);
      if (&clk_hist_p2)
        clk_filt_p3 <= 1'b1;
      else if (~(|clk_hist_p2))
        clk_filt_p3 <= 1'b0;
    end
  end

  assign timeout = (cnt == TO_LAST);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bitcnt_nxt  = bitcnt;
    shreg_nxt   = shreg;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    busy        = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (wr) begin
          shreg_nxt = {~^din, din};
          state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == INH_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_RTS;
        end
      end
      S_RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt == RTS_LAST) begin
          cnt_nxt    = '0;
          bitcnt_nxt = 4'd0;
          state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        ps2_data_oe = ~shreg[0];
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (fall_p3) begin
          cnt_nxt = '0;
          if (bitcnt == 4'd8) begin
            state_nxt = S_STOP;
          end else begin
            shreg_nxt  = {1'b1, shreg[8:1]};
            bitcnt_nxt = bitcnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (fall_p3) begin
          cnt_nxt   = '0;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          if (fall_p3)
            cnt_nxt = '0;
          // The device drives ACK before its final falling edge, so the first
          // low cycle of the filtered clock already sees it
          if (!clk_filt_p3) begin
            if (!data_sync_p1) begin
              state_nxt = S_WAITIDLE;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
      end
      S_WAITIDLE: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (clk_filt_p3 && data_sync_p1) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitcnt <= 4'd0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bitcnt <= bitcnt_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model captures frames while a
// transfer-level timeline model checks busy/oe/done/err every cycle.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int RTS = 10;
  localparam int TO  = 1500;
  localparam int FL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch       = 1'b0;
  int   dev_falls    = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // transfer-level model: cycles since acceptance and the expected ending
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_expect = 0;   // 0: done, 1: err from bad ACK, 2: err from timeout

  always #5 clk = ~clk;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .wr         (wr),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wire frame as a device sees it: d0..d7, odd parity, stop
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  always @(negedge clk) begin
    if (!m_active) begin
      check("idle_busy", busy, 0);
      check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("idle_pulse", {done, err}, 0);
    end else if (m_k <= INH + RTS) begin
      check("req_busy", busy, 1);
      check("req_clk_oe", ps2_clk_oe, 1);
      check("req_data_oe", ps2_data_oe, (m_k > INH) ? 1 : 0);
      check("req_pulse", {done, err}, 0);
    end else begin
      check("xfer_clk_oe", ps2_clk_oe, 0);
      if (done || err) begin
        check("end_busy", busy, 0);
        check("end_data_oe", ps2_data_oe, 0);
        check("end_kind", {done, err}, (m_expect == 0) ? 2'b10 : 2'b01);
        if (m_expect == 2) check("timeout_cycle", m_k, INH + RTS + 1 + TO);
        m_active = 1'b0;
      end else begin
        check("xfer_busy", busy, 1);
        if (m_k > INH + RTS + TO + 20) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_bound: no done/err after %0d cycles, required by %0d", m_k, INH + RTS + TO + 1);
          m_active = 1'b0;
        end
      end
    end
    if (m_active) m_k++;
    if (rst) begin
      m_active = 1'b0;
    end else if (wr && !m_active) begin
      m_active = 1'b1;
      m_k      = 1;
    end
  end

  task automatic device_xfer(input int half, input bit ack0, input bit glitches,
                             output logic [9:0] got);
    bit   seen_oe  = 1'b0;
    logic prev_doe = 1'b0;
    int   n        = 0;
    got = '0;
    while (n < 2 * (INH + RTS) + 100 && !(seen_oe && !ps2_clk_oe)) begin
      prev_doe = ps2_data_oe;
      if (ps2_clk_oe) seen_oe = 1'b1;
      tick(1);
      n++;
    end
    if (!(seen_oe && !ps2_clk_oe)) begin
      n_checks++;
      n_fail++;
      $display("FAIL release_wait: clk_oe=%0b after %0d cycles, required released", ps2_clk_oe, n);
      return;
    end
    check("start_bit", prev_doe, 1);
    tick($urandom_range(30, 5));
    for (int k = 0; k < 10; k++) begin
      if (glitches && ($urandom_range(1, 0) == 1)) begin
        tick(half / 2);
        glitch = 1'b1;
        tick(2);
        glitch = 1'b0;
        tick(half - half / 2 - 2);
      end else begin
        tick(half);
      end
      got[k] = ps2_data_i;
      if (k == 9 && ack0) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      dev_falls++;
      tick(half);
      dev_clk_low = 1'b0;
    end
    tick(half);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (m_active && n < bound) begin
      tick(1);
      n++;
    end
    if (m_active) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: transfer active after %0d cycles, required ended", bound);
      m_active = 1'b0;
    end
    tick(5);
  endtask

  task automatic send(input logic [7:0] d, input bit ack0, input bit glitches,
                      input int half, output logic [9:0] got);
    m_expect = ack0 ? 0 : 1;
    din = d;
    wr  = 1'b1;
    tick(1);
    wr  = 1'b0;
    din = 8'($urandom);
    device_xfer(half, ack0, glitches, got);
    wait_idle(2000);
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] d;
    bit         a;

    rst = 1'b1;
    tick(3);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {done, err}, 0);
    rst = 1'b0;
    tick(2);

    // 0xED with a second request arriving mid-transfer
    m_expect = 0;
    din = 8'hED;
    wr  = 1'b1;
    tick(1);
    wr  = 1'b0;
    din = 8'h00;
    fork
      device_xfer(40, 1'b1, 1'b0, got);
      begin
        tick(INH + RTS + 200);
        din = 8'hF4;
        wr  = 1'b1;
        tick(1);
        wr  = 1'b0;
      end
    join
    wait_idle(2000);
    check("frame_ED", got, 10'h3ED);

    send(8'hF4, 1'b1, 1'b0, 40, got);
    check("frame_F4", got, 10'h2F4);
    send(8'hFF, 1'b1, 1'b0, 35, got);
    check("frame_FF", got, 10'h3FF);
    send(8'h00, 1'b1, 1'b0, 30, got);
    check("frame_00", got, 10'h300);
    send(8'h01, 1'b1, 1'b0, 45, got);
    check("frame_01", got, 10'h201);

    // bad ACK
    send(8'hA5, 1'b0, 1'b0, 40, got);
    check("frame_badack", got, exp_frame(8'hA5));

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      a = ($urandom_range(3, 0) != 0);
      send(d, a, 1'b1, $urandom_range(45, 25), got);
      check("frame_rand", got, exp_frame(d));
    end

    // device never clocks after request-to-send
    m_expect = 2;
    din = 8'h3C;
    wr  = 1'b1;
    tick(1);
    wr  = 1'b0;
    wait_idle(2 * TO + INH + RTS + 100);

    // wr coinciding with rst is dropped
    rst = 1'b1;
    wr  = 1'b1;
    din = 8'h55;
    tick(1);
    rst = 1'b0;
    wr  = 1'b0;
    tick(3);
    check("wr_with_rst_busy", busy, 0);

    // reset while shifting bit 4
    m_expect  = 0;
    din       = 8'h96;
    wr        = 1'b1;
    tick(1);
    wr        = 1'b0;
    dev_falls = 0;
    fork
      device_xfer(40, 1'b1, 1'b0, got);
      begin
        int n = 0;
        while (dev_falls < 4 && n < 3000) begin
          tick(1);
          n++;
        end
        tick(FL + 6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pulses", {done, err}, 0);
      end
    join
    tick(50);
    send(8'hED, 1'b1, 1'b0, 40, got);
    check("frame_after_rst", got, 10'h3ED);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
